// File: rtl/card_dealer.sv
// card_dealer -- deals unique cards 1..52 from a single deck.
//
// Each deal draws random values from an external RNG (next_int / rand_int
// handshake) and rejects out-of-range values and cards already dealt. After
// MAX_TRIES rejected draws it scans the deck linearly from the last draw, so
// every deal completes in bounded time.
//
// Ports:
//   clock       system clock, all logic on posedge
//   reset       synchronous, active-high
//   deal_req    request one card (sampled only while idle)
//   new_deck    return all cards to the deck, aborts a deal in progress
//   rand_int    random value from the RNG
//   next_int    one-cycle request pulse to the RNG
//   min_n       RNG lower bound, constant 1
//   max_n       RNG upper bound (exclusive), constant 53
//   card        last dealt card 1..52, 0 = none since reset/new_deck
//   card_valid  one-cycle pulse, card updated this cycle
//   deal_err    one-cycle pulse, deal_req while the deck is empty
//   busy        high whenever a deal is in progress
//   cards_left  undealt cards, 0..52
//   deck_empty  high when cards_left == 0
module card_dealer #(
   parameter int RNG_LATENCY = 2,
   parameter int MAX_TRIES   = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        deal_req,
   input  logic        new_deck,
   input  logic [15:0] rand_int,
   output logic        next_int,
   output logic [15:0] min_n,
   output logic [15:0] max_n,
   output logic [5:0]  card,
   output logic        card_valid,
   output logic        deal_err,
   output logic        busy,
   output logic [5:0]  cards_left,
   output logic        deck_empty
);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_CHECK, S_SCAN} state_t;

   // tries_q counts draws already rejected in this deal; the last allowed
   // draw is the one seen with tries_q == MAX_TRIES-1.
   localparam int TRY_W  = (MAX_TRIES   > 1) ? $clog2(MAX_TRIES)   : 1;
   localparam int WAIT_W = (RNG_LATENCY > 1) ? $clog2(RNG_LATENCY) : 1;
   localparam logic [TRY_W-1:0]  TRY_LAST  = TRY_W'(MAX_TRIES - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RNG_LATENCY - 1);

   state_t            state_q, state_d;
   logic [51:0]       dealt_q, dealt_d;
   logic [5:0]        cards_left_q, cards_left_d;
   logic [5:0]        card_q, card_d;
   logic [5:0]        idx_q, idx_d;
   logic [TRY_W-1:0]  tries_q, tries_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              card_valid_q, card_valid_d;
   logic              deal_err_q, deal_err_d;

   logic [63:0] dealt_ext;
   logic        rand_in_range;
   logic        rand_free;
   logic        idx_free;
   logic        do_deal;
   logic [5:0]  pick;

   // Bitmap padded to 64 bits so any 6-bit index stays in range; bit k-1
   // holds card k.
   assign dealt_ext     = {12'd0, dealt_q};
   assign rand_in_range = (rand_int >= 16'd1) && (rand_int <= 16'd52);
   assign rand_free     = rand_in_range && !dealt_ext[rand_int[5:0] - 6'd1];
   assign idx_free      = !dealt_ext[idx_q - 6'd1];

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         // NOTE: the bitmap is the deck itself, not scratch storage, so it
         // must be cleared by reset like any other control state.
         dealt_q      <= '0;
         cards_left_q <= 6'd52;
         card_q       <= '0;
         idx_q        <= 6'd1;
         tries_q      <= '0;
         wait_q       <= '0;
         card_valid_q <= 1'b0;
         deal_err_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking here so every flop samples pre-edge values.
         state_q      <= state_d;
         dealt_q      <= dealt_d;
         cards_left_q <= cards_left_d;
         card_q       <= card_d;
         idx_q        <= idx_d;
         tries_q      <= tries_d;
         wait_q       <= wait_d;
         card_valid_q <= card_valid_d;
         deal_err_q   <= deal_err_d;
      end
   end

   // Next-state and datapath
   always_comb begin
      // NOTE: every signal gets a default first, so no path leaves one
      // unassigned and no latch is inferred.
      state_d      = state_q;
      dealt_d      = dealt_q;
      cards_left_d = cards_left_q;
      card_d       = card_q;
      idx_d        = idx_q;
      tries_d      = tries_q;
      wait_d       = wait_q;
      card_valid_d = 1'b0;
      deal_err_d   = 1'b0;
      do_deal      = 1'b0;
      pick         = rand_int[5:0];

      case (state_q)
         S_IDLE: begin
            if (deal_req) begin
               if (cards_left_q != 6'd0) begin
                  state_d = S_REQ;
                  tries_d = '0;
               end else begin
                  deal_err_d = 1'b1;
               end
            end
         end
         S_REQ: begin
            state_d = S_WAIT;
            wait_d  = '0;
         end
         S_WAIT: begin
            if (wait_q == WAIT_LAST) state_d = S_CHECK;
            else                     wait_d  = wait_q + WAIT_W'(1);
         end
         S_CHECK: begin
            if (rand_free) begin
               do_deal = 1'b1;
               pick    = rand_int[5:0];
            end else if (tries_q == TRY_LAST) begin
               // Scan starts at the last drawn card, or card 1 if the draw
               // was out of range.
               state_d = S_SCAN;
               idx_d   = rand_in_range ? rand_int[5:0] : 6'd1;
            end else begin
               tries_d = tries_q + TRY_W'(1);
               state_d = S_REQ;
            end
         end
         S_SCAN: begin
            if (idx_free) begin
               do_deal = 1'b1;
               pick    = idx_q;
            end else begin
               idx_d = (idx_q == 6'd52) ? 6'd1 : idx_q + 6'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (do_deal) begin
         dealt_d      = dealt_q | (52'd1 << (pick - 6'd1));
         card_d       = pick;
         cards_left_d = cards_left_q - 6'd1;
         card_valid_d = 1'b1;
         state_d      = S_IDLE;
      end

      // A fresh deck overrides whatever the FSM was doing this cycle.
      if (new_deck) begin
         state_d      = S_IDLE;
         dealt_d      = '0;
         cards_left_d = 6'd52;
         card_d       = '0;
         card_valid_d = 1'b0;
         deal_err_d   = 1'b0;
      end
   end

   // Outputs
   always_comb begin
      next_int = (state_q == S_REQ);
      busy     = (state_q != S_IDLE);
   end

   assign min_n      = 16'd1;
   assign max_n      = 16'd53;
   assign card       = card_q;
   assign card_valid = card_valid_q;
   assign deal_err   = deal_err_q;
   assign cards_left = cards_left_q;
   assign deck_empty = (cards_left_q == 6'd0);

endmodule
